// File: rtl/ps2_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_scan_ctrl
//   Turns a stream of raw PS/2 set-2 scan bytes into press/release events.
//   A four-state prefix decoder (IDLE, E0, F0, E0F0) folds the 0xE0
//   (extended) and 0xF0 (break) prefixes into the following code byte.
//   Each completed event is written into a small event FIFO on the same
//   clock edge that samples its final byte, so it becomes visible on
//   evt_vld one cycle after the strobe. The block also tracks the most
//   recently pressed key (held / last_key) and counts accepted presses.
//
// Parameters
//   FIFO_DEPTH : event FIFO entries, power of two, >= 2
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   byte_in   : raw scan byte from the PS/2 receiver
//   byte_vld  : one-cycle strobe qualifying byte_in
//   evt_code  : scan code of the FIFO head event
//   evt_ext   : head event carried the E0 prefix
//   evt_brk   : head event is a release (1) or a press (0)
//   evt_vld   : FIFO non-empty, head fields valid
//   evt_rdy   : consumer accepts the head when evt_vld=1
//   held      : a key is currently held
//   key_cnt   : count of accepted press events (wraps at 8 bits)
//   err       : one-cycle pulse on a prefix protocol error
//   overflow  : sticky, an event was dropped because the FIFO was full
//
// Build option
//   PS2_SCAN_REPEAT_FILTER_EN : when defined, a typematic repeat (a press
//   equal to last_key while held=1) is discarded before reaching the FIFO.
// ---------------------------------------------------------------------------
module ps2_scan_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_vld,
  input  logic       evt_rdy,
  output logic       held,
  output logic [7:0] key_cnt,
  output logic       err,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  state_t state, state_nxt;

  // decoder outputs for the byte presented this cycle
  logic emit;
  logic ev_ext;
  logic ev_brk;
  logic proto_err;

  // FIFO storage and bookkeeping
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          drop;
  logic          repeat_drop;
  logic [8:0]    last_key;
  evt_t          head;
  evt_t          new_evt;

  // -------------------------------------------------------------------------
  // Prefix decoder: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Prefix decoder: next state and event decode
  // -------------------------------------------------------------------------
  always_comb begin
    logic is_e0;
    logic is_f0;
    state_nxt = state;
    emit      = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    proto_err = 1'b0;
    is_e0     = (byte_in == BYTE_E0);
    is_f0     = (byte_in == BYTE_F0);
    if (byte_vld) begin
      unique case (state)
        ST_IDLE: begin
          if (is_e0) begin
            state_nxt = ST_E0;
          end else if (is_f0) begin
            state_nxt = ST_F0;
          end else begin
            emit = 1'b1;
          end
        end
        ST_E0: begin
          if (is_f0) begin
            state_nxt = ST_E0F0;
          end else if (is_e0) begin
            state_nxt = ST_E0;
          end else begin
            emit      = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_F0: begin
          state_nxt = ST_IDLE;
          if (is_e0 || is_f0) begin
            proto_err = 1'b1;
          end else begin
            emit   = 1'b1;
            ev_brk = 1'b1;
          end
        end
        ST_E0F0: begin
          state_nxt = ST_IDLE;
          if (is_e0 || is_f0) begin
            proto_err = 1'b1;
          end else begin
            emit   = 1'b1;
            ev_ext = 1'b1;
            ev_brk = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Repeat filter and FIFO push/pop qualification
  // -------------------------------------------------------------------------
`ifdef PS2_SCAN_REPEAT_FILTER_EN
  assign repeat_drop = emit && !ev_brk && held && ({ev_ext, byte_in} == last_key);
`else
  assign repeat_drop = 1'b0;
`endif

  assign new_evt   = '{brk: ev_brk, ext: ev_ext, code: byte_in};
  assign fifo_full = (count == FULL_CNT);
  assign evt_vld   = (count != '0);
  assign pop       = evt_vld && evt_rdy;
  assign push_req  = emit && !repeat_drop;
  // A full FIFO still accepts when the head leaves in the same cycle; an
  // empty FIFO never pops, so a push there is always written, not bypassed.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && !push_ok;

  // -------------------------------------------------------------------------
  // FIFO storage (no reset needed: contents are only visible while count>0)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_evt;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers, occupancy, key tracking and status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      key_cnt  <= '0;
      held     <= 1'b0;
      last_key <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      err <= proto_err;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push_ok && pop) begin
        count <= count - CNT_ONE;
      end
      if (push_ok) begin
        if (!ev_brk) begin
          key_cnt  <= key_cnt + 8'd1;
          held     <= 1'b1;
          last_key <= {ev_ext, byte_in};
        end else if ({ev_ext, byte_in} == last_key) begin
          held <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Head fields, forced to zero while the FIFO is empty
  // -------------------------------------------------------------------------
  assign head     = mem[rd_ptr];
  assign evt_code = evt_vld ? head.code : '0;
  assign evt_ext  = evt_vld ? head.ext  : 1'b0;
  assign evt_brk  = evt_vld ? head.brk  : 1'b0;

endmodule
